// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit: FSM states, RV32I size codes,
// byte-enable size masks and the request legality check.
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } lsu_state_t;

    typedef enum logic [2:0] {
        LB  = 3'd0,
        LH  = 3'd1,
        LW  = 3'd2,
        LBU = 3'd4,
        LHU = 3'd5
    } load_funct3_t;

    typedef enum logic [2:0] {
        SB = 3'd0,
        SH = 3'd1,
        SW = 3'd2
    } store_funct3_t;

    localparam logic [3:0] MASK_BYTE = 4'b0001;
    localparam logic [3:0] MASK_HALF = 4'b0011;
    localparam logic [3:0] MASK_WORD = 4'b1111;

    // funct3[1:0] encodes the access size for both loads and stores.
    function automatic logic [3:0] size_mask(input logic [2:0] funct3);
        logic [3:0] mask;
        case (funct3[1:0])
            2'd0:    mask = MASK_BYTE;
            2'd1:    mask = MASK_HALF;
            default: mask = MASK_WORD;
        endcase
        return mask;
    endfunction

    function automatic logic req_error(input logic       we,
                                       input logic [2:0] funct3,
                                       input logic [1:0] addr_lo);
        logic illegal;
        logic misaligned;
        illegal = 1'b0;
        if (we) begin
            case (funct3)
                SB, SH, SW: illegal = 1'b0;
                default:    illegal = 1'b1;
            endcase
        end else begin
            case (funct3)
                LB, LH, LW, LBU, LHU: illegal = 1'b0;
                default:              illegal = 1'b1;
            endcase
        end
        case (funct3[1:0])
            2'd1:    misaligned = addr_lo[0];
            2'd2:    misaligned = (addr_lo != 2'b00);
            default: misaligned = 1'b0;
        endcase
        return illegal | misaligned;
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Picks the addressed byte/halfword out of a little-endian memory word and
// sign- or zero-extends it according to the load funct3.
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [31:0] rd_data,
    input  logic [1:0]  addr,
    input  logic [2:0]  funct3,
    output logic [31:0] rdata
);

    logic [31:0] shifted;

    assign shifted = rd_data >> {addr, 3'b000};

    always_comb begin
        rdata = '0;
        case (funct3)
            LB:      rdata = {{24{shifted[7]}}, shifted[7:0]};
            LH:      rdata = {{16{shifted[15]}}, shifted[15:0]};
            LW:      rdata = shifted;
            LBU:     rdata = {24'h000000, shifted[7:0]};
            LHU:     rdata = {16'h0000, shifted[15:0]};
            default: rdata = '0;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding RV32I load/store unit: request handshake, one memory
// access cycle, then a held response until the consumer takes it.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [2:0]            req_funct3,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_err,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_wr_en,
    output logic [DATA_WIDTH-1:0] mem_wr_data,
    output logic [3:0]            mem_byte_en,
    input  logic [DATA_WIDTH-1:0] mem_rd_data
);

    lsu_state_t state;
    lsu_state_t state_next;

    logic                  we_q;
    logic [2:0]            funct3_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  err_q;

    logic                  req_fire;
    logic                  req_err;
    logic [DATA_WIDTH-1:0] load_data;

    assign req_fire = req_valid && req_ready;
    assign req_err  = req_error(req_we, req_funct3, req_addr[1:0]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Errors skip the memory cycle entirely so nothing can be written for them.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (req_fire) state_next = req_err ? RESP : ACCESS;
            ACCESS:  state_next = RESP;
            RESP:    if (resp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        req_ready   = (state == IDLE);
        resp_valid  = (state == RESP);
        mem_wr_en   = (state == ACCESS) && we_q;
        mem_byte_en = (state == ACCESS) ? (size_mask(funct3_q) << addr_q[1:0]) : 4'b0000;
    end

    // Request fields only change on acceptance, so the response stays stable in RESP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q     <= 1'b0;
            funct3_q <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            if (req_fire) begin
                we_q     <= req_we;
                funct3_q <= req_funct3;
                addr_q   <= req_addr;
                wdata_q  <= req_wdata;
                err_q    <= req_err;
                rdata_q  <= '0;
            end
            if (state == ACCESS && !we_q) begin
                rdata_q <= load_data;
            end
        end
    end

    lsu_load_align u_load_align (
        .rd_data (mem_rd_data),
        .addr    (addr_q[1:0]),
        .funct3  (funct3_q),
        .rdata   (load_data)
    );

    assign mem_addr    = {addr_q[ADDR_WIDTH-1:2], 2'b00};
    assign mem_wr_data = wdata_q << {addr_q[1:0], 3'b000};
    assign resp_rdata  = rdata_q;
    assign resp_err    = err_q;

endmodule
